// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//   Groups the serial line and the received-word signals of the UART
//   receiver into one bundle.
//
//   Signals:
//     rx          serial line into the receiver (asynchronous, idle high)
//     data_out    last good word received
//     data_valid  one-cycle strobe, data_out is new in this cycle
//     frame_err   one-cycle strobe, a stop bit was sampled low
//     parity_err  one-cycle strobe, parity mismatch (0 without parity)
//     busy        receiver is somewhere inside a frame
//
//   Modports:
//     master  the receiver itself (consumes rx, drives the results)
//     slave   the host side (drives rx, consumes the results)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int UART_DATA_BITS = 8
);

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_valid;
  logic                      frame_err;
  logic                      parity_err;
  logic                      busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Asynchronous serial receiver. Recovers frames of UART_DATA_BITS data
//   bits (LSB first) followed by UART_STOP_BITS stop bits from a raw rx pin,
//   using a 2-FF synchroniser and mid-bit sampling. Each good word is
//   presented on data_out together with a single-cycle data_valid strobe.
//   There is no FIFO: the consumer must take data_out in the strobe cycle.
//
//   Optional feature (macro UART_RX_PARITY_EN):
//     defined   - a parity bit follows the data bits; parity is even unless
//                 PARITY_ODD is set. A mismatch with good stop bits pulses
//                 parity_err instead of data_valid.
//     undefined - no parity bit, parity_err is tied low.
//
//   Ports:
//     clk    input   system clock
//     rst_n  input   synchronous active-low reset
//     rx_if  uart_rx_if.master
//              rx          serial line, idle high
//              data_out    last received word, held until the next good frame
//              data_valid  one-cycle pulse, data_out is new
//              frame_err   one-cycle pulse, a stop bit was low
//              parity_err  one-cycle pulse, parity mismatch
//              busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_2_CLOCK_RATIO = 1250,
  parameter int UART_DATA_BITS     = 8,
  parameter int UART_STOP_BITS     = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master rx_if
);

  localparam int CNT_W = $clog2(BAUD_2_CLOCK_RATIO);
  localparam int HALF  = BAUD_2_CLOCK_RATIO / 2;
  localparam int BIT_W = 4;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(UART_STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_ODD = 1'b0;
`endif

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;
`endif

  // Synchroniser and edge detection
  logic       s1_q;
  logic       s2_q;
  logic       s2Dly_q;
  logic [1:0] fresh_q;
  logic       armed_q;

  // Frame state
  state_t                    state_q,    state_d;
  logic [CNT_W-1:0]          cnt_q,      cnt_d;
  logic [BIT_W-1:0]          bitIdx_q,   bitIdx_d;
  logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
  logic                      stopErr_q,  stopErr_d;
  logic [UART_DATA_BITS-1:0] data_q,     data_d;
  logic                      valid_q,    valid_d;
  logic                      frameErr_q, frameErr_d;
`ifdef UART_RX_PARITY_EN
  logic                      parErr_q,    parErr_d;
  logic                      parityErr_q, parityErr_d;
`endif

  logic baudTick;
  logic stopLow;
  logic startEdge;

  // Two-flop synchroniser on the raw pin plus one more delay stage for
  // falling-edge detection. The flops reset to the idle level, so right
  // after reset s2 does not yet reflect the line. fresh_q marks when s2
  // carries a real sample, and armed_q only goes high once the line has
  // been seen idle-high after that. This keeps a line that is low when
  // reset is released (e.g. reset in the middle of a frame) from being
  // mistaken for a start edge; the receiver waits for a genuine edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s2Dly_q <= 1'b1;
      fresh_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= rx_if.rx;
      s2_q    <= s1_q;
      s2Dly_q <= s2_q;
      fresh_q <= {fresh_q[0], 1'b1};
      armed_q <= armed_q | (fresh_q[1] & s2_q);
    end
  end

  assign startEdge = armed_q & s2Dly_q & ~s2_q;
  assign baudTick  = (cnt_q == BAUD_LAST);

  // State register and registered outputs. Pulses are registered so they
  // are glitch-free and last exactly one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      stopErr_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErr_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      stopErr_q   <= stopErr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
      parErr_q    <= parErr_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  // Next-state logic. The baud counter runs from 0 to BAUD_LAST between
  // samples; START waits only half a bit so that every later sample falls
  // in the middle of its bit. The result of a frame is decided at the
  // middle of the last stop bit, which returns to IDLE about half a bit
  // early and lets a back-to-back start edge be caught.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    stopErr_d   = stopErr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frameErr_d  = 1'b0;
    stopLow     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parErr_d    = parErr_q;
    parityErr_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (startEdge) begin
          state_d   = START;
          stopErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          parErr_d  = 1'b0;
`endif
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          // A line that is high again at mid start bit was only a glitch
          if (s2_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baudTick) begin
          cnt_d   = '0;
          // LSB arrives first, so shift in from the top
          shift_d = {s2_q, shift_q[UART_DATA_BITS-1:1]};
          if (bitIdx_q == DATA_LAST) begin
            bitIdx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baudTick) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          // Data bits plus parity bit must XOR to PARITY_ODD
          parErr_d = (^shift_q) ^ s2_q ^ PARITY_ODD;
          state_d  = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (baudTick) begin
          cnt_d   = '0;
          stopLow = stopErr_q | ~s2_q;
          if (bitIdx_q == STOP_LAST) begin
            bitIdx_d  = '0;
            stopErr_d = 1'b0;
            // Framing error wins over parity error; neither updates data
            if (stopLow) begin
              frameErr_d = 1'b1;
              state_d    = BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (parErr_q) begin
              parityErr_d = 1'b1;
              state_d     = IDLE;
`endif
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stopErr_d = stopLow;
            bitIdx_d  = bitIdx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BREAK: begin
        // A held-low line must go high before a new start edge counts
        cnt_d    = '0;
        bitIdx_d = '0;
        if (s2_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        bitIdx_d = '0;
      end
    endcase
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.frame_err  = frameErr_q;
  assign rx_if.busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parityErr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed and randomized bench for uart_rx at 16 clocks per bit, 8 data
//   bits and 2 stop bits. A monitor logs every strobe with the data_out seen
//   at that moment; the expected event list is built from frame rules
//   (good frame -> word, any low stop bit -> framing error, bad parity ->
//   parity error) and compared in order.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int RATIO = 16;
  localparam int NBITS = 8;
  localparam int NSTOP = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int EXP_LAT = 2 + RATIO / 2 + (NBITS + NPAR + NSTOP) * RATIO + 1;

  localparam int EV_VALID  = 0;
  localparam int EV_FRAME  = 1;
  localparam int EV_PARITY = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;

  uart_rx_if #(.UART_DATA_BITS(NBITS)) ifc ();

  uart_rx #(
    .BAUD_2_CLOCK_RATIO(RATIO),
    .UART_DATA_BITS    (NBITS),
    .UART_STOP_BITS    (NSTOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx_if(ifc)
  );

  // 10 ns clock and a free-running cycle counter used for latency
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor on the falling edge: logs each strobe and counts protocol
  // violations (overlapping strobes, strobes longer than one cycle, busy
  // not dropping together with data_valid)
  ev_t  gotQ[$];
  int   validCnt = 0, frameCnt = 0, parityCnt = 0;
  int   lastValidCycle = 0;
  int   overlapCnt = 0, longPulseCnt = 0, busyBad = 0;
  logic prevValid = 1'b0, prevFrame = 1'b0, prevParity = 1'b0, prevBusy = 1'b0;

  always @(negedge clk) begin
    if (ifc.data_valid === 1'b1) begin
      validCnt       <= validCnt + 1;
      lastValidCycle <= cycle;
      gotQ.push_back('{EV_VALID, ifc.data_out});
      if (ifc.busy !== 1'b0 || prevBusy !== 1'b1) busyBad <= busyBad + 1;
    end
    if (ifc.frame_err === 1'b1) begin
      frameCnt <= frameCnt + 1;
      gotQ.push_back('{EV_FRAME, ifc.data_out});
    end
    if (ifc.parity_err === 1'b1) begin
      parityCnt <= parityCnt + 1;
      gotQ.push_back('{EV_PARITY, ifc.data_out});
    end
    if ((ifc.data_valid && ifc.frame_err) || (ifc.data_valid && ifc.parity_err) ||
        (ifc.frame_err && ifc.parity_err))
      overlapCnt <= overlapCnt + 1;
    if ((ifc.data_valid && prevValid) || (ifc.frame_err && prevFrame) ||
        (ifc.parity_err && prevParity))
      longPulseCnt <= longPulseCnt + 1;
    prevValid  <= ifc.data_valid;
    prevFrame  <= ifc.frame_err;
    prevParity <= ifc.parity_err;
    prevBusy   <= ifc.busy;
  end

  int assertions = 0;
  int failures   = 0;

  // Drive the line to v for n clocks; changes land 1 ns after a rising edge
  task automatic applyStimulus(input logic v, input int n);
    #1 ifc.rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete frame; stopVals[0] is the first stop bit
  task automatic sendFrame(input logic [7:0] d, input logic [1:0] stopVals,
                           input logic parFlip, output int startCycle);
    #1 ifc.rx = 1'b0;
    startCycle = cycle;
    repeat (RATIO) @(posedge clk);
    for (int i = 0; i < NBITS; i++) applyStimulus(d[i], RATIO);
`ifdef UART_RX_PARITY_EN
    applyStimulus((^d) ^ parFlip, RATIO);
`endif
    for (int s = 0; s < NSTOP; s++) applyStimulus(stopVals[s], RATIO);
  endtask

  initial begin
    int         st;
    int         lat;
    int         vBase;
    int         base;
    logic [7:0] expData;
    logic [7:0] d;
    logic [1:0] stops;
    logic       flip;
    ev_t        expQ[$];

    $display("[TB] uart_rx bench, %0d clocks per bit, expected latency %0d", RATIO, EXP_LAT);
    ifc.rx  = 1'b1;
    rst_n   = 1'b0;
    expData = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Reset state
    @(negedge clk);
    checkOutput("reset_data_out", ifc.data_out, 0);
    checkOutput("reset_data_valid", ifc.data_valid, 0);
    checkOutput("reset_frame_err", ifc.frame_err, 0);
    checkOutput("reset_parity_err", ifc.parity_err, 0);
    checkOutput("reset_busy", ifc.busy, 0);

    // Clean byte
    sendFrame(8'hA5, 2'b11, 1'b0, st);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    expData = 8'hA5;
    lat = lastValidCycle - st;
    checkOutput("clean_valid_count", validCnt, 1);
    checkOutput("clean_data_out", ifc.data_out, expData);
    checkOutput("clean_frame_err", frameCnt, 0);
    checkOutput("clean_latency_window", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);

    // Glitch shorter than half a bit
    applyStimulus(1'b0, 5);
    @(negedge clk);
    checkOutput("glitch_busy_during", ifc.busy, 1);
    applyStimulus(1'b1, 10);
    @(negedge clk);
    checkOutput("glitch_busy_after", ifc.busy, 0);
    checkOutput("glitch_no_valid", validCnt, 1);
    checkOutput("glitch_no_frame_err", frameCnt, 0);
    applyStimulus(1'b1, RATIO);

    // Framing error: second stop bit low, line then held low
    sendFrame(8'h3C, 2'b01, 1'b0, st);
    applyStimulus(1'b0, 40);
    @(negedge clk);
    checkOutput("ferr_pulse_count", frameCnt, 1);
    checkOutput("ferr_data_kept", ifc.data_out, expData);
    checkOutput("ferr_no_valid", validCnt, 1);
    checkOutput("ferr_busy_in_break", ifc.busy, 1);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    checkOutput("ferr_busy_released", ifc.busy, 0);
    sendFrame(8'h5A, 2'b11, 1'b0, st);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    expData = 8'h5A;
    checkOutput("ferr_recover_valid", validCnt, 2);
    checkOutput("ferr_recover_data", ifc.data_out, expData);

    // Back-to-back frames with no idle gap
    base = gotQ.size();
    sendFrame(8'h00, 2'b11, 1'b0, st);
    sendFrame(8'hFF, 2'b11, 1'b0, st);
    sendFrame(8'h81, 2'b11, 1'b0, st);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    expData = 8'h81;
    checkOutput("b2b_event_count", gotQ.size() - base, 3);
    if (gotQ.size() - base == 3) begin
      checkOutput("b2b_word0", {gotQ[base].kind[23:0], gotQ[base].data}, {24'(EV_VALID), 8'h00});
      checkOutput("b2b_word1", {gotQ[base+1].kind[23:0], gotQ[base+1].data}, {24'(EV_VALID), 8'hFF});
      checkOutput("b2b_word2", {gotQ[base+2].kind[23:0], gotQ[base+2].data}, {24'(EV_VALID), 8'h81});
    end
    checkOutput("b2b_no_frame_err", frameCnt, 1);

    // Reset during bit 3 of 0x55, line stays low briefly after release
    vBase = validCnt;
    #1 ifc.rx = 1'b0;
    repeat (RATIO) @(posedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(1'(8'h55 >> i), RATIO);
    applyStimulus(1'b0, RATIO / 2);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (RATIO / 2 - 1) @(posedge clk);
    applyStimulus(1'b1, 14 * RATIO);
    @(negedge clk);
    expData = 8'h00;
    checkOutput("rst_mid_no_valid", validCnt, vBase);
    checkOutput("rst_mid_no_frame_err", frameCnt, 1);
    checkOutput("rst_mid_data_out", ifc.data_out, expData);
    checkOutput("rst_mid_busy", ifc.busy, 0);
    sendFrame(8'h12, 2'b11, 1'b0, st);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    expData = 8'h12;
    checkOutput("rst_mid_next_valid", validCnt, vBase + 1);
    checkOutput("rst_mid_next_data", ifc.data_out, expData);

`ifdef UART_RX_PARITY_EN
    // Parity: correct even parity, then inverted parity bit
    vBase = validCnt;
    sendFrame(8'h07, 2'b11, 1'b0, st);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    expData = 8'h07;
    checkOutput("par_good_valid", validCnt, vBase + 1);
    checkOutput("par_good_data", ifc.data_out, expData);
    sendFrame(8'h07, 2'b11, 1'b1, st);
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    checkOutput("par_bad_pulse", parityCnt, 1);
    checkOutput("par_bad_no_valid", validCnt, vBase + 1);
`endif

    // Randomized frames against the frame-rule model
    base = gotQ.size();
    for (int n = 0; n < 24; n++) begin
      d     = 8'($urandom_range(0, 255));
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      flip  = (NPAR != 0) && ($urandom_range(0, 3) == 0);
      sendFrame(d, stops, flip, st);
      if (stops != 2'b11) begin
        expQ.push_back('{EV_FRAME, expData});
        applyStimulus(1'b1, 2 * RATIO);
      end else if (flip) begin
        expQ.push_back('{EV_PARITY, expData});
        applyStimulus(1'b1, int'($urandom_range(0, 2)) * RATIO);
      end else begin
        expData = d;
        expQ.push_back('{EV_VALID, expData});
        applyStimulus(1'b1, int'($urandom_range(0, 2)) * RATIO);
      end
    end
    applyStimulus(1'b1, 2 * RATIO);
    @(negedge clk);
    checkOutput("rand_event_count", gotQ.size() - base, expQ.size());
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++) begin
      checkOutput($sformatf("rand_event%0d", i),
                  {gotQ[base+i].kind[23:0], gotQ[base+i].data},
                  {expQ[i].kind[23:0], expQ[i].data});
    end
    checkOutput("rand_final_data", ifc.data_out, expData);

    // Protocol properties over the whole run
    checkOutput("strobe_overlap", overlapCnt, 0);
    checkOutput("strobe_length", longPulseCnt, 0);
    checkOutput("busy_with_valid", busyBad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
